// File: rtl/sr_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_drv_pkg
// Brief    : Shared encodings and default parameters for the SR command driver.
// Revision : 1.0 - initial release
// ============================================================================
package sr_drv_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PULSE = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;
    localparam logic [1:0] c_CHECK = 2'd3;

    localparam logic c_CMD_SET = 1'b0;
    localparam logic c_CMD_RST = 1'b1;

    localparam int c_DEF_DB_CYCLES = 4;
    localparam int c_DEF_PULSE_W   = 2;
    localparam int c_DEF_GAP_W     = 1;
    localparam int c_DEF_CNT_W     = 8;

endpackage
`default_nettype wire

// File: rtl/sr_cmd_driver_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sr_debounce
// Brief    : Two-flop synchroniser, debounce counter and debounced-rise strobe.
// Revision : 1.0 - initial release
// ============================================================================
module sr_debounce
    import sr_drv_pkg::*;
#(
    parameter int DB_CYCLES = c_DEF_DB_CYCLES,
    parameter int CNT_W     = c_DEF_CNT_W
) (
    input  logic clk,
    input  logic clear,
    input  logic din,
    output logic rise
);

    localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_flip;

    assign w_diff = r_sync2 ^ r_level;
    // The flip strobe is combinational so the pending flag lands on the same edge as the level.
    assign w_flip = w_diff && (r_cnt == c_DB_LAST);
    assign rise   = w_flip & r_sync2;

    always_ff @(posedge clk) begin
        if (!clear) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (w_flip) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sr_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_cmd_driver
// Brief    : Debounced set/reset request to clean s/r pulse driver with q check.
// Revision : 1.0 - initial release
// ============================================================================
module sr_cmd_driver
    import sr_drv_pkg::*;
#(
    parameter int DB_CYCLES = c_DEF_DB_CYCLES,
    parameter int PULSE_W   = c_DEF_PULSE_W,
    parameter int GAP_W     = c_DEF_GAP_W,
    parameter int CNT_W     = c_DEF_CNT_W
) (
    input  logic clk,
    input  logic clear,
    input  logic set_in,
    input  logic rst_in,
    input  logic q_fb,
    output logic s_out,
    output logic r_out,
    output logic busy,
    output logic done,
    output logic conflict,
    output logic mismatch,
    output logic exp_q
);

    localparam int c_CNT_MAX = (2 ** CNT_W) - 1;

    if ((DB_CYCLES < 1) || (DB_CYCLES > c_CNT_MAX) ||
        (PULSE_W < 1)   || (PULSE_W > c_CNT_MAX)   ||
        (GAP_W < 1)     || (GAP_W > c_CNT_MAX)) begin : g_bad_params
        $fatal(1, "sr_cmd_driver: timing parameter outside 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] c_PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] c_GAP_LOAD   = CNT_W'(GAP_W - 1);

    logic             w_rise_s;
    logic             w_rise_r;
    logic             w_cap_s;
    logic             w_cap_r;
    logic             w_take;
    logic             w_pick_rst;
    logic             w_clr_s;
    logic             w_clr_r;
    logic             w_exp_new;
    logic             w_cnt_zero;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd;
    logic             r_pend_s;
    logic             r_pend_r;
    logic             r_order;
    logic             r_conflict;
    logic             r_mismatch;
    logic             r_exp_q;

    sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_set (
        .clk   (clk),
        .clear (clear),
        .din   (set_in),
        .rise  (w_rise_s)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_rst (
        .clk   (clk),
        .clear (clear),
        .din   (rst_in),
        .rise  (w_rise_r)
    );

    // Simultaneous rises cancel each other: neither request is captured.
    assign w_cap_s    = w_rise_s & ~w_rise_r;
    assign w_cap_r    = w_rise_r & ~w_rise_s;
    // r_order set means the reset request is the older one.
    assign w_pick_rst = r_pend_r & (~r_pend_s | r_order);
    assign w_take     = (r_state == c_IDLE) & (r_pend_s | r_pend_r);
    assign w_clr_s    = w_take & ~w_pick_rst;
    assign w_clr_r    = w_take &  w_pick_rst;
    assign w_exp_new  = (r_cmd == c_CMD_SET);
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!clear) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_cmd      <= c_CMD_SET;
            r_pend_s   <= 1'b0;
            r_pend_r   <= 1'b0;
            r_order    <= 1'b0;
            r_conflict <= 1'b0;
            r_mismatch <= 1'b0;
            r_exp_q    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_conflict <= w_rise_s & w_rise_r;
            r_pend_s   <= (r_pend_s & ~w_clr_s) | w_cap_s;
            r_pend_r   <= (r_pend_r & ~w_clr_r) | w_cap_r;
            if (w_cap_s && !(r_pend_r && !w_clr_r)) begin
                r_order <= 1'b0;
            end else if (w_cap_r && !(r_pend_s && !w_clr_s)) begin
                r_order <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_take) begin
                        r_cnt <= c_PULSE_LOAD;
                        r_cmd <= w_pick_rst ? c_CMD_RST : c_CMD_SET;
                    end
                end
                c_PULSE: r_cnt <= w_cnt_zero ? c_GAP_LOAD : r_cnt - 1'b1;
                c_GAP:   r_cnt <= w_cnt_zero ? r_cnt : r_cnt - 1'b1;
                c_CHECK: begin
                    r_exp_q <= w_exp_new;
                    if (q_fb != w_exp_new) begin
                        r_mismatch <= 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_take)     w_state_nxt = c_PULSE;
            c_PULSE: if (w_cnt_zero) w_state_nxt = c_GAP;
            c_GAP:   if (w_cnt_zero) w_state_nxt = c_CHECK;
            c_CHECK: w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        s_out    = (r_state == c_PULSE) && (r_cmd == c_CMD_SET);
        r_out    = (r_state == c_PULSE) && (r_cmd == c_CMD_RST);
        busy     = (r_state != c_IDLE);
        done     = (r_state == c_CHECK);
        conflict = r_conflict;
        mismatch = r_mismatch;
        exp_q    = r_exp_q;
    end

endmodule
`default_nettype wire

// File: doc/sr_cmd_driver.md
Name: sr_cmd_driver

Overview:
Upstream driver stage for the gated SR flip-flop (s/r/clk inputs, q feedback).
- Accepts raw, possibly bouncing set and reset request lines.
- Synchronises and debounces both lines, then converts rising edges into clean, width-controlled s/r pulses.
- Never drives s and r high together.
- After each command, checks the flip-flop's q against the expected value.

Parameters:
- DB_CYCLES, 4: consecutive stable cycles before a debounced level changes (1..255).
- PULSE_W, 2: cycles s_out/r_out is held high per command (1..255).
- GAP_W, 1: low cycles after a pulse before q is checked (1..255).
- CNT_W, 8: width of the internal counters.

Ports:
- clk, in, 1: single clock, rising edge.
- clear, in, 1: synchronous active-low reset.
- set_in, in, 1: raw asynchronous set request.
- rst_in, in, 1: raw asynchronous reset request.
- q_fb, in, 1: q from the downstream SR flip-flop.
- s_out, out, 1: set pulse to the flip-flop.
- r_out, out, 1: reset pulse to the flip-flop.
- busy, out, 1: command in progress.
- done, out, 1: one-cycle pulse when a command completes.
- conflict, out, 1: one-cycle pulse when set and reset requests are discarded.
- mismatch, out, 1: sticky flag, q_fb differed from the expected value.
- exp_q, out, 1: expected flip-flop state.

Behaviour:
- Reset: clk, with clear synchronous and active-low. While clear=0 at an edge:
  - all outputs go to 0;
  - the FSM goes to IDLE;
  - sync flops, debounced levels, counters and pending flags clear.
  - Reset mid-pulse drops s_out/r_out on the same edge; no done pulse.
- Input path, per line (set_in and rst_in):
  - 2-flop synchroniser.
  - Debounce counter counts consecutive cycles where the synced value differs from the debounced level.
  - The level flips when the count reaches DB_CYCLES; the counter resets on any agreeing cycle.
- Edge detection:
  - A debounced 0->1 sets a pending flag, registered one edge later.
  - A second rise of the same line while its flag is pending merges (dropped).
- Conflict:
  - Both debounced rises on the same edge: neither flag is set, and conflict pulses for 1 cycle.
- Ordering: if both flags are pending, the older one is serviced first. An order bit is recorded on capture.
- Latency: s_out (or r_out) rises DB_CYCLES+3 edges after the first edge sampling the raw input high, provided the FSM is IDLE.
- FSM states:
  - IDLE: busy=0. If a flag is pending, clear it, load the counter with PULSE_W-1, assert s_out or r_out, and go to PULSE.
  - PULSE: output held high for exactly PULSE_W cycles. At count 0, deassert and load GAP_W-1, then go to GAP.
  - GAP: s_out=r_out=0 for GAP_W cycles, then go to CHECK.
  - CHECK: one cycle.
    - done=1.
    - exp_q updates: 1 for set, 0 for reset.
    - If q_fb differs from the new exp_q, mismatch is set.
    - Return to IDLE.
- busy=1 in PULSE, GAP and CHECK.
- Invariant: s_out & r_out is never 1.
- mismatch is cleared only by clear.
- Requests arriving while busy are captured as pending and serviced after return to IDLE. Minimum command spacing is PULSE_W+GAP_W+2 cycles.
- Counters are CNT_W bits. Parameters above 2^CNT_W-1 are illegal; this is checked by an elaboration-time assertion.

Decomposition:
- Package sr_drv_pkg:
  - FSM state encoding: IDLE, PULSE, GAP, CHECK.
  - Command encoding: CMD_SET, CMD_RST.
  - Default parameter constants.
- Sub-module sr_debounce: synchroniser, debounce counter and rising-edge output.
  - Parameters DB_CYCLES and CNT_W.
  - Instantiated twice, once per request line.
- Top level holds the pending flags, order bit, FSM and checker.

Test Plan:
1. Reset: hold clear=0 for 3 cycles with set_in=1 -> all outputs 0 throughout. After release, s_out rises 7 edges later (DB_CYCLES=4), then stays high for 2 cycles.
2. Set command, with q_fb tied to s_out's effect (model latch):
   - s_out high 2 cycles, 1 gap cycle, done pulses once;
   - exp_q=1, mismatch=0, busy high for 4 cycles.
3. Bounce: toggle set_in every 2 cycles for 20 cycles, then hold at 1 -> exactly one s_out pulse, starting 7 edges after the final rise.
4. Simultaneous: set_in and rst_in rise on the same edge -> conflict pulses 1 cycle; no s_out/r_out; busy stays 0.
5. Back-to-back: set_in rises, rst_in rises 3 cycles later -> the s pulse completes, then the r pulse starts the cycle after the next IDLE. Check:
   - s_out and r_out are never high together;
   - done pulses twice;
   - final exp_q=0.
6. Faulty latch: q_fb stuck at 0 during a set command -> mismatch=1 at CHECK and remains 1 through later commands until clear=0.
